// File: rtl/pma_region_unit.sv
// Programmable PMA region checker: registered lookup, lockable entries.
// Optional saturating lookup/miss counters under PMA_REGION_STATS_EN.
module pma_region_unit #(
  parameter int unsigned NrRegions = 4,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRegions*AddrWidth-1:0] RstBase = '0,
  parameter logic [NrRegions*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRegions*4-1:0] RstAttr = '0,
  localparam int unsigned IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_idx_o,
  output logic [2:0]           rsp_attr_o,
  input  logic                 cfg_valid_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_ack_o,
  output logic                 cfg_err_o,
  output logic [31:0]          stat_lookups_o,
  output logic [31:0]          stat_misses_o
);

  logic [AddrWidth-1:0] r_base [NrRegions];
  logic [AddrWidth-1:0] r_len  [NrRegions];
  logic [3:0]           r_attr [NrRegions];

  logic [AddrWidth:0]   w_end [NrRegions];
  logic [NrRegions-1:0] w_match;
  logic                 w_hit;
  logic [IdxW-1:0]      w_idx;
  logic [2:0]           w_attr;
  logic                 w_acc;
  logic                 w_idx_ok;
  logic                 w_cfg_err;

  logic                 r_rsp_valid;
  logic                 r_rsp_hit;
  logic [IdxW-1:0]      r_rsp_idx;
  logic [2:0]           r_rsp_attr;
  logic                 r_ack;
  logic                 r_err;

  // End address in AddrWidth+1 bits so a region never wraps to zero
  always_comb begin
    for (int i = 0; i < int'(NrRegions); i++) begin
      w_end[i]   = {1'b0, r_base[i]} + {1'b0, r_len[i]};
      w_match[i] = (r_len[i] != '0)
                && (lkp_addr_i >= r_base[i])
                && ({1'b0, lkp_addr_i} < w_end[i]);
    end
  end

  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_attr = '0;
    for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit  = 1'b1;
        w_idx  = IdxW'(i);
        w_attr = r_attr[i][2:0];
      end
    end
  end

  assign w_acc       = lkp_valid_i && lkp_ready_o;
  assign lkp_ready_o = !r_rsp_valid || rsp_ready_i;

  assign w_idx_ok  = 32'(cfg_idx_i) < NrRegions;
  assign w_cfg_err = !w_idx_ok
                  || (cfg_field_i == 2'd3)
                  || r_attr[cfg_idx_i][3];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NrRegions); i++) begin
        r_base[i] <= RstBase[i*AddrWidth +: AddrWidth];
        r_len[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        r_attr[i] <= RstAttr[i*4 +: 4];
      end
    end else if (cfg_valid_i && !w_cfg_err) begin
      unique case (cfg_field_i)
        2'd0:    r_base[cfg_idx_i] <= cfg_wdata_i;
        2'd1:    r_len[cfg_idx_i]  <= cfg_wdata_i;
        2'd2:    r_attr[cfg_idx_i] <= cfg_wdata_i[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= cfg_valid_i;
      r_err <= cfg_valid_i && w_cfg_err;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_attr  <= '0;
    end else if (w_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_hit   <= w_hit;
      r_rsp_idx   <= w_idx;
      r_rsp_attr  <= w_attr;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_hit_o   = r_rsp_hit;
  assign rsp_idx_o   = r_rsp_idx;
  assign rsp_attr_o  = r_rsp_attr;
  assign cfg_ack_o   = r_ack;
  assign cfg_err_o   = r_err;

`ifdef PMA_REGION_STATS_EN
  logic [31:0] r_lookups;
  logic [31:0] r_misses;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lookups <= '0;
      r_misses  <= '0;
    end else if (w_acc) begin
      if (r_lookups != '1) r_lookups <= r_lookups + 32'd1;
      if (!w_hit && r_misses != '1) r_misses <= r_misses + 32'd1;
    end
  end

  assign stat_lookups_o = r_lookups;
  assign stat_misses_o  = r_misses;
`else
  assign stat_lookups_o = '0;
  assign stat_misses_o  = '0;
`endif

endmodule
